bus_line_xfer: RTL

- Parametrised cache-line bus engine. It moves one full line between a cache and the system bus, in either direction.
- Write mode: writeback. Requests the bus arbiter, sends an aligned address beat, then streams LINE_BEATS data beats.
- Read mode: fill. Sends the address beat, then collects LINE_BEATS tagged response beats into a line register.
- Sits between the L1 cache controllers and the bus arbiter. It is the successor to the fixed 8-beat write-only line store.

---
 rtl/bus_line_xfer.sv | 131 +++++++++++++
 1 files changed

// File: rtl/bus_line_xfer.sv
// Cache-line bus engine: writes back or fills one line over the system bus
// after winning arbitration, with an aligned address beat ahead of the data.
module bus_line_xfer #(
   parameter int                        BUS_DATA_WIDTH = 64,
   parameter int                        BUS_TAG_WIDTH  = 13,
   parameter int                        LINE_BEATS     = 8,
   parameter logic [BUS_TAG_WIDTH-1:0]  TAG_WRITE      = 13'h1100,
   parameter logic [BUS_TAG_WIDTH-1:0]  TAG_READ       = 13'h0100
) (
   input  logic                                 clk,
   input  logic                                 reset,
   input  logic                                 start,
   input  logic                                 write,
   input  logic [BUS_DATA_WIDTH-1:0]            addr,
   input  logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] wdata,
   output logic [BUS_DATA_WIDTH*LINE_BEATS-1:0] rdata,
   output logic                                 ready,
   output logic                                 busy,
   output logic                                 abtr_reqcyc,
   input  logic                                 abtr_grant,
   output logic                                 bus_busy,
   output logic                                 main_bus_reqcyc,
   input  logic                                 main_bus_reqack,
   output logic [BUS_DATA_WIDTH-1:0]            main_bus_req,
   output logic [BUS_TAG_WIDTH-1:0]             main_bus_reqtag,
   input  logic                                 main_bus_respcyc,
   input  logic [BUS_DATA_WIDTH-1:0]            main_bus_resp,
   input  logic [BUS_TAG_WIDTH-1:0]             main_bus_resptag,
   output logic                                 main_bus_respack
);

   localparam int IDX_W  = $clog2(LINE_BEATS);
   localparam int CNT_W  = IDX_W + 1;
   localparam int OFF_W  = $clog2(LINE_BEATS * BUS_DATA_WIDTH / 8);
   localparam int LINE_W = BUS_DATA_WIDTH * LINE_BEATS;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LINE_BEATS - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_ARB, S_ADDR, S_WBEAT, S_RWAIT, S_DONE
   } state_t;

   state_t                    state, state_next;
   logic [CNT_W-1:0]          cnt;
   logic                      write_q;
   logic [BUS_DATA_WIDTH-1:0] addr_q;
   logic [LINE_W-1:0]         wdata_q;
   logic [LINE_W-1:0]         rdata_q;
   logic [BUS_DATA_WIDTH-1:0] addr_aligned;
   logic [IDX_W-1:0]          idx;
   logic                      accept;

   // The address beat always names the first byte of the line.
   assign addr_aligned = addr_q & ({BUS_DATA_WIDTH{1'b1}} << OFF_W);
   assign idx          = cnt[IDX_W-1:0];
   assign rdata        = rdata_q;
   assign busy         = (state != S_IDLE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next       = state;
      abtr_reqcyc      = 1'b0;
      bus_busy         = 1'b0;
      main_bus_reqcyc  = 1'b0;
      main_bus_req     = '0;
      main_bus_reqtag  = '0;
      main_bus_respack = 1'b0;
      ready            = 1'b0;
      accept           = 1'b0;
      case (state)
         S_IDLE: if (start) state_next = S_ARB;
         S_ARB: begin
            abtr_reqcyc = 1'b1;
            if (abtr_grant) state_next = S_ADDR;
         end
         S_ADDR: begin
            bus_busy        = 1'b1;
            main_bus_reqcyc = 1'b1;
            main_bus_req    = addr_aligned;
            main_bus_reqtag = write_q ? TAG_WRITE : TAG_READ;
            if (main_bus_reqack) state_next = write_q ? S_WBEAT : S_RWAIT;
         end
         S_WBEAT: begin
            bus_busy        = 1'b1;
            main_bus_reqcyc = 1'b1;
            main_bus_reqtag = TAG_WRITE;
            main_bus_req    = wdata_q[idx*BUS_DATA_WIDTH +: BUS_DATA_WIDTH];
            if (cnt == LAST) state_next = S_DONE;
         end
         S_RWAIT: begin
            bus_busy         = 1'b1;
            accept           = main_bus_respcyc && (main_bus_resptag == TAG_READ);
            main_bus_respack = accept;
            if (accept && cnt == LAST) state_next = S_DONE;
         end
         S_DONE: begin
            ready      = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

   // Request fields are captured only from IDLE so a stray start cannot
   // corrupt a line already on the bus.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt     <= '0;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         if (state == S_IDLE && start) begin
            write_q <= write;
            addr_q  <= addr;
            wdata_q <= wdata;
         end
         if (state == S_ARB && abtr_grant) cnt <= '0;
         if (state == S_WBEAT) cnt <= cnt + 1'b1;
         if (accept) begin
            rdata_q[idx*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= main_bus_resp;
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule
